// File: rtl/lcd_pkg.sv
// HD44780 command constants, controller state encoding and DDRAM row address helper.
package lcd_pkg;

  localparam logic [7:0] FUNC_8B2L  = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY_INC  = 8'h06;
  localparam logic [7:0] CGRAM_BASE = 8'h40;

  // Rows 2 and 3 continue the DDRAM lines of rows 0 and 1, offset by one row width.
  localparam logic [7:0] DDRAM_ROW [0:3] = '{8'h80, 8'hC0, 8'h80, 8'hC0};

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FUNC,
    S_DISP_ON,
    S_CLEAR,
    S_CLR_WAIT,
    S_MODE,
    S_CG_HOME,
    S_CG_WRITE,
    S_FRAME_START,
    S_ROW_ADDR,
    S_PRINT
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_DROP,
    PH_HOLD
  } bus_phase_t;

  function automatic logic [7:0] ddram_row_cmd(input logic [1:0] row, input int cols);
    logic [7:0] offset;
    offset = (row >= 2'd2) ? 8'(cols) : 8'h00;
    return DDRAM_ROW[row] + offset;
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider producing a one-clock step tick every DIV clocks.
module lcd_tick_gen #(
  parameter int DIV = 125000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; the tick marks the final count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780 write controller: init sequence, optional CGRAM load, then continuous
// refresh of a double-buffered ROWSxCOLS text frame.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 400,
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int CG_BYTES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*ROWS*COLS-1:0]   text,
  input  logic                     text_valid,
  output logic                     text_ready,
  output logic [5:0]               cg_addr,
  input  logic [7:0]               cg_data,
  output logic [7:0]               lcd_data,
  output logic                     lcd_en,
  output logic                     lcd_rs,
  output logic                     lcd_rw,
  output logic                     init_done,
  output logic                     frame_done
);

  localparam int N   = ROWS * COLS;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = $clog2(8 * N);

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [1:0] ROW_LAST = 2'(ROWS - 1);
  localparam logic [5:0] CG_LAST  = (CG_BYTES > 0) ? 6'(CG_BYTES - 1) : 6'd0;

  logic tick;

  lcd_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  lcd_state_t state_q, state_d;
  bus_phase_t phase_q, phase_d;
  logic [1:0]    wait_q, wait_d;
  logic [1:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [5:0]    cg_addr_d;
  logic [7:0]    data_d;
  logic          en_d, rs_d, init_done_d, frame_done_d;
  logic          load_active;

  logic [8*N-1:0] pending_q, active_q;
  logic           pend_q;

  logic          is_write;
  logic [7:0]    write_val;
  logic [BW-1:0] char_lsb;
  logic [7:0]    cur_char;

  assign lcd_rw     = 1'b0;
  assign text_ready = !pend_q;

  assign char_lsb = BW'(8 * (N - 1 - int'(idx_q)));
  assign cur_char = active_q[char_lsb +: 8];

  // Select the byte the current write state puts on the bus.
  always_comb begin
    is_write  = 1'b1;
    write_val = 8'h00;
    case (state_q)
      S_FUNC:     write_val = FUNC_8B2L;
      S_DISP_ON:  write_val = DISP_ON;
      S_CLEAR:    write_val = CLEAR;
      S_MODE:     write_val = ENTRY_INC;
      S_CG_HOME:  write_val = CGRAM_BASE;
      S_CG_WRITE: write_val = cg_data;
      S_ROW_ADDR: write_val = ddram_row_cmd(row_q, COLS);
      S_PRINT:    write_val = cur_char;
      default:    is_write  = 1'b0;
    endcase
  end

  // Next-state logic: each write spends one tick each in ISSUE, DROP and HOLD.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wait_d       = wait_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    cg_addr_d    = cg_addr;
    en_d         = lcd_en;
    rs_d         = lcd_rs;
    data_d       = lcd_data;
    init_done_d  = init_done;
    frame_done_d = 1'b0;
    load_active  = 1'b0;
    if (tick) begin
      if (is_write) begin
        case (phase_q)
          PH_ISSUE: begin
            en_d    = 1'b1;
            rs_d    = (state_q == S_CG_WRITE) || (state_q == S_PRINT);
            data_d  = write_val;
            phase_d = PH_DROP;
          end
          PH_DROP: begin
            en_d    = 1'b0;
            phase_d = PH_HOLD;
          end
          default: begin
            phase_d = PH_ISSUE;
            case (state_q)
              S_FUNC:    state_d = S_DISP_ON;
              S_DISP_ON: state_d = S_CLEAR;
              S_CLEAR:   state_d = S_CLR_WAIT;
              S_MODE: begin
                if (CG_BYTES > 0) begin
                  cg_addr_d = 6'd0;
                  state_d   = S_CG_HOME;
                end else begin
                  init_done_d = 1'b1;
                  state_d     = S_FRAME_START;
                end
              end
              S_CG_HOME: state_d = S_CG_WRITE;
              S_CG_WRITE: begin
                if (cg_addr == CG_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = S_FRAME_START;
                end else begin
                  cg_addr_d = cg_addr + 6'd1;
                end
              end
              S_ROW_ADDR: state_d = S_PRINT;
              S_PRINT: begin
                idx_d = idx_q + IW'(1);
                if (col_q == COL_LAST) begin
                  col_d = 5'd0;
                  if (row_q == ROW_LAST) begin
                    row_d        = 2'd0;
                    idx_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_FRAME_START;
                  end else begin
                    row_d   = row_q + 2'd1;
                    state_d = S_ROW_ADDR;
                  end
                end else begin
                  col_d = col_q + 5'd1;
                end
              end
              default: state_d = state_q;
            endcase
          end
        endcase
      end else begin
        case (state_q)
          S_PWR_WAIT: begin
            if (wait_q == 2'd3) begin
              wait_d  = 2'd0;
              state_d = S_FUNC;
            end else begin
              wait_d = wait_q + 2'd1;
            end
          end
          S_CLR_WAIT: state_d = S_MODE;
          S_FRAME_START: begin
            load_active = pend_q;
            row_d       = 2'd0;
            col_d       = 5'd0;
            idx_d       = '0;
            state_d     = S_ROW_ADDR;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Controller state and registered LCD-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PWR_WAIT;
      phase_q    <= PH_ISSUE;
      wait_q     <= 2'd0;
      row_q      <= 2'd0;
      col_q      <= 5'd0;
      idx_q      <= '0;
      cg_addr    <= 6'd0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      cg_addr    <= cg_addr_d;
      lcd_en     <= en_d;
      lcd_rs     <= rs_d;
      lcd_data   <= data_d;
      init_done  <= init_done_d;
      frame_done <= frame_done_d;
    end
  end

  // Double buffer: accept into pending, promote to active only at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= {N{8'h20}};
      active_q  <= {N{8'h20}};
      pend_q    <= 1'b0;
    end else if (load_active) begin
      active_q <= pending_q;
      pend_q   <= 1'b0;
    end else if (text_valid && text_ready) begin
      pending_q <= text;
      pend_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Self-checking bench: 16x2 controller with 8 CGRAM bytes plus a 4x20 controller without CGRAM.
module tb_lcd_char_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] text;
  logic         text_valid;
  logic         text_ready;
  logic [5:0]   cg_addr;
  logic [7:0]   cg_data;
  logic [7:0]   lcd_data;
  logic         lcd_en, lcd_rs, lcd_rw, init_done, frame_done;

  logic [639:0] text4 = {80{8'h20}};
  logic         text_ready4;
  logic [5:0]   cg_addr4;
  logic [7:0]   cg_data4;
  logic [7:0]   lcd_data4;
  logic         lcd_en4, lcd_rs4, lcd_rw4, init_done4, frame_done4;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  bit log4_on = 1'b1;

  logic [8:0] q[$];
  logic [8:0] q4[$];

  always #5 clk = ~clk;

  assign cg_data  = {2'b00, cg_addr} ^ 8'h55;
  assign cg_data4 = {2'b00, cg_addr4} ^ 8'h55;

  lcd_char_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .COLS(16), .ROWS(2), .CG_BYTES(8)) dut (
    .clk(clk), .rst(rst), .text(text), .text_valid(text_valid), .text_ready(text_ready),
    .cg_addr(cg_addr), .cg_data(cg_data), .lcd_data(lcd_data), .lcd_en(lcd_en),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .init_done(init_done), .frame_done(frame_done)
  );

  lcd_char_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .COLS(20), .ROWS(4), .CG_BYTES(0)) dut4 (
    .clk(clk), .rst(rst), .text(text4), .text_valid(1'b0), .text_ready(text_ready4),
    .cg_addr(cg_addr4), .cg_data(cg_data4), .lcd_data(lcd_data4), .lcd_en(lcd_en4),
    .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .init_done(init_done4), .frame_done(frame_done4)
  );

  // LCD bus models: capture (rs, data) as the enable strobe falls.
  always @(negedge lcd_en) if (!rst) q.push_back({lcd_rs, lcd_data});
  always @(negedge lcd_en4) if (!rst && log4_on) q4.push_back({lcd_rs4, lcd_data4});

  // Frame completion bookkeeping.
  always @(posedge frame_done) fd_cnt++;
  always @(posedge frame_done4) log4_on = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expectLog(input string tag, input logic [8:0] exp);
    logic [31:0] got;
    got = 32'hDEAD;
    if (q.size() > 0) got = 32'(q.pop_front());
    checkOutput(tag, got, 32'(exp));
  endtask

  function automatic logic [255:0] frame16(input string s);
    logic [255:0] r;
    r = {32{8'h20}};
    for (int i = 0; i < s.len(); i++) r[8*(31-i) +: 8] = s[i];
    return r;
  endfunction

  task automatic checkFrame16(input string tag, input logic [255:0] f);
    expectLog({tag, "_row0"}, 9'h080);
    for (int i = 0; i < 16; i++) expectLog($sformatf("%s_c%0d", tag, i), {1'b1, f[8*(31-i) +: 8]});
    expectLog({tag, "_row1"}, 9'h0C0);
    for (int i = 16; i < 32; i++) expectLog($sformatf("%s_c%0d", tag, i), {1'b1, f[8*(31-i) +: 8]});
    checkOutput({tag, "_extra"}, 32'(q.size()), 32'd0);
  endtask

  task automatic waitFrameDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (frame_done) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic applyStimulus(input logic [255:0] f, input int bound, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    text       = f;
    text_valid = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (text_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    text_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] hello, fa, fb;
    logic [8:0]   init_exp[$];
    logic [8:0]   exp4[$];
    bit           found, ok;
    int           data_cnt;

    hello = frame16("HELLO");
    fa    = {32{8'h41}};
    fb    = {32{8'h42}};
    init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h040,
                 9'h155, 9'h154, 9'h157, 9'h156, 9'h151, 9'h150, 9'h153, 9'h152};

    rst = 1'b0; text = {32{8'h20}}; text_valid = 1'b0;
    #2 rst = 1'b1;
    #20;
    checkOutput("rst_en", 32'(lcd_en), 0);
    checkOutput("rst_rs", 32'(lcd_rs), 0);
    checkOutput("rst_data", 32'(lcd_data), 0);
    checkOutput("rst_rw", 32'(lcd_rw), 0);
    checkOutput("rst_init_done", 32'(init_done), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_ready", 32'(text_ready), 1);
    checkOutput("rst_cg_addr", 32'(cg_addr), 0);
    checkOutput("rst_ready4", 32'(text_ready4), 1);

    // Start init, then reset while CGRAM byte 3 is on the bus.
    @(negedge clk) rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (cg_addr == 6'd3 && lcd_en) found = 1'b1;
    end
    checkOutput("reach_cg_byte3", 32'(found), 1);
    checkOutput("cg3_data", 32'(lcd_data), 32'h56);
    rst = 1'b1;
    #1;
    checkOutput("midrst_en", 32'(lcd_en), 0);
    checkOutput("midrst_data", 32'(lcd_data), 0);
    checkOutput("midrst_rs", 32'(lcd_rs), 0);
    checkOutput("midrst_cg_addr", 32'(cg_addr), 0);
    checkOutput("midrst_init_done", 32'(init_done), 0);
    q.delete();
    q4.delete();
    log4_on = 1'b1;
    fd_cnt  = 0;
    #20;

    // Offer HELLO during init; it must be taken immediately and shown first.
    text = hello; text_valid = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    text_valid = 1'b0;
    checkOutput("pend_after_offer", 32'(text_ready), 0);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (init_done) found = 1'b1;
    end
    checkOutput("init_done_rise", 32'(found), 1);
    checkOutput("init_len", 32'(q.size()), 13);
    for (int i = 0; i < 13; i++) expectLog($sformatf("init%0d", i), init_exp[i]);
    checkOutput("cg_addr_hold", 32'(cg_addr), 7);

    waitFrameDone("f1_done");
    checkFrame16("f1", hello);
    checkOutput("f1_pulse_cnt", 32'(fd_cnt), 1);

    // Double-buffer handshake: A mid-frame, B held off until A is promoted.
    repeat (300) @(negedge clk);
    applyStimulus(fa, 50, ok);
    checkOutput("accept_a", 32'(ok), 1);
    checkOutput("ready_low_after_a", 32'(text_ready), 0);
    applyStimulus(fb, 3000, ok);
    checkOutput("accept_b", 32'(ok), 1);
    checkOutput("b_after_f2", 32'(fd_cnt), 2);
    checkFrame16("f2", hello);
    waitFrameDone("f3_done");
    checkFrame16("f3", fa);
    waitFrameDone("f4_done");
    checkFrame16("f4", fb);

    // 4x20 instance without CGRAM: MODE goes straight to the first row address.
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(posedge clk); #1;
      if (!log4_on) found = 1'b1;
    end
    checkOutput("f4x20_done", 32'(found), 1);
    exp4 = '{9'h038, 9'h00C, 9'h001, 9'h006};
    for (int r = 0; r < 4; r++) begin
      exp4.push_back((r == 0) ? 9'h080 : (r == 1) ? 9'h0C0 : (r == 2) ? 9'h094 : 9'h0D4);
      for (int c = 0; c < 20; c++) exp4.push_back(9'h120);
    end
    checkOutput("len_4x20", 32'(q4.size()), 88);
    data_cnt = 0;
    for (int i = 0; i < 88; i++) begin
      if (i < q4.size()) begin
        if (q4[i][8]) data_cnt++;
        checkOutput($sformatf("w4_%0d", i), 32'(q4[i]), 32'(exp4[i]));
      end
    end
    checkOutput("data_cnt_4x20", 32'(data_cnt), 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
